// File: rtl/arb_rr_lock.sv
// rtl/arb_rr_lock.sv - round-robin output-port arbiter with wormhole lock
// Optional lock watchdog enabled by defining ARB_TIMEOUT_EN.
module arb_rr_lock #(
  parameter int PORT_ID = 0,
  parameter int NUM_IN  = 5,
  parameter int PORT_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*PORT_W-1:0] req_port,
  input  logic [NUM_IN-1:0]        req_valid,
  input  logic                     flit_fire,
  input  logic                     flit_tail,
  output logic [PORT_W-1:0]        grant,
  output logic [NUM_IN-1:0]        grant_oh,
  output logic                     grant_valid,
  output logic                     timeout
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam logic [PORT_W-1:0] IDLE_CODE = PORT_W'(NUM_IN);

  if (((1 << PORT_W) <= NUM_IN) || (TIMEOUT < 1)) begin : g_param_check
    $error("arb_rr_lock: PORT_W too narrow for NUM_IN or TIMEOUT < 1");
  end

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   grant_q, grant_d;
  logic [NUM_IN-1:0]   grant_oh_q, grant_oh_d;
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_IN-1:0]   match;
  logic                found;
  logic [PORT_W-1:0]   win;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      match[i] = req_valid[i] && (req_port[i*PORT_W +: PORT_W] == PORT_W'(PORT_ID));
    end
  end

  // Two passes: channels at or above rr_ptr first, then the wrapped part.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && match[i] && (PORT_W'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        win   = PORT_W'(i);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && match[i]) begin
        found = 1'b1;
        win   = PORT_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= IDLE_CODE;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_LOCKED;
          grant_d    = win;
          grant_oh_d = NUM_IN'(1) << win;
          rr_ptr_d   = (win == PORT_W'(NUM_IN - 1)) ? '0 : win + 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_LOCKED: begin
        if (flit_fire && flit_tail) begin
          state_d    = S_IDLE;
          grant_d    = IDLE_CODE;
          grant_oh_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        // Forced release leaves rr_ptr alone; the holder already advanced it.
        else if (!flit_fire && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d    = S_IDLE;
          grant_d    = IDLE_CODE;
          grant_oh_d = '0;
          timeout_d  = 1'b1;
        end else if (flit_fire) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_oh    = grant_oh_q;
    grant_valid = (state_q == S_LOCKED);
`ifdef ARB_TIMEOUT_EN
    timeout     = timeout_q;
`else
    timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_arb_rr_lock.sv
// tb/tb_arb_rr_lock.sv - directed-vector bench for arb_rr_lock
module tb_arb_rr_lock;

  localparam int NUM_IN = 5;
  localparam int PORT_W = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IN*PORT_W-1:0] req_port;
  logic [NUM_IN-1:0]        req_valid;
  logic                     flit_fire;
  logic                     flit_tail;
  logic [PORT_W-1:0]        grant;
  logic [NUM_IN-1:0]        grant_oh;
  logic                     grant_valid;
  logic                     timeout;

  int vectors    = 0;
  int miscompares = 0;

  arb_rr_lock #(
    .PORT_ID(0),
    .NUM_IN (NUM_IN),
    .PORT_W (PORT_W),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_port   (req_port),
    .req_valid  (req_valid),
    .flit_fire  (flit_fire),
    .flit_tail  (flit_tail),
    .grant      (grant),
    .grant_oh   (grant_oh),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'd5);
    check({tag, ".oh"}, 32'(grant_oh), 32'd0);
    check({tag, ".gv"}, 32'(grant_valid), 32'd0);
  endtask

  task automatic expect_grant(input string tag, input int g);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".oh"}, 32'(grant_oh), 32'(1 << g));
    check({tag, ".gv"}, 32'(grant_valid), 32'd1);
  endtask

  int exp_seq [11] = '{0, 5, 1, 5, 2, 5, 3, 5, 4, 5, 0};

  initial begin
    rst       = 1'b0;
    req_port  = '0;
    req_valid = 5'b11111;
    flit_fire = 1'b0;
    flit_tail = 1'b0;

    // Reset held two edges with every channel requesting
    tick();
    expect_idle("rst0");
    check("rst0.to", 32'(timeout), 32'd0);
    tick();
    expect_idle("rst1");
    rst = 1'b1;
    tick();
    expect_grant("first", 0);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("first_rel");

    // Fresh reset, then only E and PE request
    flit_fire = 1'b0; flit_tail = 1'b0;
    rst = 1'b0; req_valid = '0;
    tick();
    rst = 1'b1; req_valid = 5'b10010;
    tick();
    expect_grant("pe_e.g1", 1);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("pe_e.gap");
    flit_fire = 1'b0; flit_tail = 1'b0;
    tick();
    expect_grant("pe_e.g4", 4);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("pe_e.rel");

    // Fairness: all request, single-flit packets every granted cycle
    req_valid = 5'b11111;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("rr[%0d].grant", k), 32'(grant), 32'(exp_seq[k]));
      check($sformatf("rr[%0d].gv", k), 32'(grant_valid), (exp_seq[k] == 5) ? 32'd0 : 32'd1);
    end
    tick();
    expect_idle("rr.end");

    // Lock hold on S with N competing, bodies and a bubble
    flit_fire = 1'b0; flit_tail = 1'b0;
    req_valid = 5'b00101;
    tick();
    expect_grant("hold.g", 2);
    flit_fire = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_grant($sformatf("hold.body%0d", k), 2);
    end
    flit_fire = 1'b0; req_valid = 5'b00001;
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_grant($sformatf("hold.bubble%0d", k), 2);
    end
    req_valid = 5'b00101; flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("hold.tail");
    flit_fire = 1'b0; flit_tail = 1'b0;
    tick();
    expect_grant("hold.next", 0);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("hold.rel");

    // W asks for port 3 and must never win port 0
    flit_fire = 1'b0; flit_tail = 1'b0;
    req_port[3*PORT_W +: PORT_W] = 3'd3;
    req_valid = 5'b01000;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_idle($sformatf("mism%0d", k));
    end
    req_valid = 5'b01001;
    tick();
    expect_grant("mid.g", 0);
    flit_fire = 1'b1;
    tick();
    expect_grant("mid.body", 0);
    // Reset mid-packet with E also requesting: rr_ptr back to 0 means N wins
    flit_fire = 1'b0;
    req_valid = 5'b01011;
    rst = 1'b0;
    tick();
    expect_idle("mid.rst");
    rst = 1'b1;
    tick();
    expect_grant("mid.regrant", 0);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("mid.rel");

    // Watchdog
    flit_fire = 1'b0; flit_tail = 1'b0;
    req_valid = 5'b00001;
    tick();
    expect_grant("wd.g", 0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      expect_grant($sformatf("wd.hold%0d", k), 0);
      check($sformatf("wd.to%0d", k), 32'(timeout), 32'd0);
    end
    tick();
    expect_idle("wd.fire");
    check("wd.pulse", 32'(timeout), 32'd1);
    tick();
    check("wd.pulse_end", 32'(timeout), 32'd0);
    expect_grant("wd.regrant", 0);
    for (int k = 1; k < 8; k++) tick();
    expect_grant("wd.edge", 0);
    flit_fire = 1'b1; flit_tail = 1'b1;
    tick();
    expect_idle("wd.tail");
    check("wd.tail_to", 32'(timeout), 32'd0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      check($sformatf("nowd.grant%0d", k), 32'(grant), 32'd0);
      check($sformatf("nowd.to%0d", k), 32'(timeout), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_rr_lock.md
Name: arb_rr_lock

Overview:
- Parametrised output-port arbiter for the NoC router; one instance per output port.
- Each input channel presents a requested output-port code plus a valid flag. The block picks one channel whose request matches PORT_ID.
- Arbitration is round-robin. The winner keeps the grant (wormhole lock) until the output port accepts its tail flit.
- Registered grant code drives the router crossbar select for this output.

Parameters:
- PORT_ID, 0: output-port code this instance serves (0=N, 1=E, 2=S, 3=W, 4=PE).
- NUM_IN, 5: number of input channels. Channel i has index i: 0=N, 1=E, 2=S, 3=W, 4=PE.
- PORT_W, 3: width of port codes and grant. Must satisfy 2^PORT_W > NUM_IN.
- TIMEOUT, 64: lock watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the next rising edge of clk).
- req_port  input  NUM_IN*PORT_W  requested output code per channel; channel i occupies bits [i*PORT_W +: PORT_W].
- req_valid  input  NUM_IN  channel i has a head/body flit pending.
- flit_fire  input  1  output port accepted a flit from the granted channel this cycle.
- flit_tail  input  1  the flit accepted with flit_fire is a tail; qualified by flit_fire.
- grant  output  PORT_W  registered winner index. Value NUM_IN means no grant (idle code; 5 by default).
- grant_oh  output  NUM_IN  registered one-hot of grant; all zeros when idle.
- grant_valid  output  1  1 while in LOCKED.
- timeout  output  1  one-cycle pulse on watchdog release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Match vector: m[i] = req_valid[i] && (req_port slice i == PORT_ID).
- Reset (rst==0 at a clock edge):
  - state=IDLE, grant=NUM_IN, grant_oh=0, grant_valid=0, timeout=0.
  - rr_ptr=0, watchdog counter=0.
  - Reset takes priority over every other event. A lock held mid-packet is dropped.
- State IDLE:
  - If m==0, hold the idle outputs.
  - Otherwise choose the first i with m[i]=1, searching circularly from rr_ptr: rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - On that edge: grant=i, grant_oh=1<<i, grant_valid=1, state=LOCKED.
  - rr_ptr=(i+1) mod NUM_IN, so rr_ptr wraps from NUM_IN-1 to 0.
  - Latency: a match sampled at edge k is visible on grant after edge k. The inputs are combinational into the registers; the outputs are registered.
- State LOCKED:
  - grant is frozen regardless of m, including when the holder deasserts req_valid (bubble inside a packet).
  - If flit_fire && flit_tail: state=IDLE, grant=NUM_IN, grant_oh=0, grant_valid=0. No new arbitration happens on that edge; the earliest re-grant is the following edge (one idle cycle).
  - flit_fire && !flit_tail: no change.
- flit_fire or flit_tail in IDLE is ignored.
- A single-flit packet is granted, then released on the edge where fire and tail are both 1.
- Fairness: with all NUM_IN channels continuously requesting PORT_ID, grants rotate 0,1,...,NUM_IN-1,0,...
- A channel whose req_port does not equal PORT_ID is never granted.
- Values of req_port slices at or above NUM_IN never match when PORT_ID is a valid port.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An unsigned counter (width sufficient for TIMEOUT) clears on entry to LOCKED and on every flit_fire.
  - It increments on each LOCKED cycle without flit_fire.
  - When the counter reaches TIMEOUT-1 while LOCKED and flit_fire=0, the next edge forces IDLE (idle outputs) and pulses timeout=1 for exactly one cycle.
  - rr_ptr is not changed by the forced release.
  - A tail release takes precedence when it coincides with the forced release (timeout stays 0).
- Not defined: no counter logic; timeout is tied to 0; the lock is held indefinitely until the tail.

Test Plan:
- Reset with rst=0 for 2 cycles while all channels request port 0 -> grant=5, grant_oh=0, grant_valid=0 throughout; after rst=1, first edge gives grant=0 (N), grant_oh=00001.
- After reset, only PE(4) and E(1) request port 0 -> grant=1; fire+tail -> grant=5 for one cycle, then grant=4 (rr_ptr=2 searches 2,3,4).
- All 5 channels request port 0 continuously, single-flit packets fired every granted cycle -> grant sequence 0,5,1,5,2,5,3,5,4,5,0.
- Lock hold: grant=2 (S), 3 body flits fired without tail while N also requests and S drops req_valid for 2 cycles -> grant stays 2; tail fire -> grant=5.
- Mismatch and reset mid-packet: channel W requests port 3 with PORT_ID=0 -> never granted; lock on N, then rst=0 for one edge mid-packet -> grant=5, rr_ptr=0, N re-granted after rst=1.
- With ARB_TIMEOUT_EN and TIMEOUT=8: lock N, no flit_fire -> 8 cycles after grant appears, grant=5 and timeout pulses 1 for one cycle; without the macro, grant stays 0 for 100 cycles and timeout is always 0.
